i2s_dac_serializer: RTL and testbench
=====================================

// Module: i2s_dac_serializer
// PURPOSE
//  Transmit end of the codec audio link: takes parallel 16-bit stereo samples
//  from dsp_subsystem and serializes them to the codec DAC in I2S format.
//  Generates bclk, lrclk and dacdat from the single system clock.
//  Uses a one-frame holding buffer with valid/ready handshake. Sits between the
//  DSP output mux and the codec pins.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits per channel sample, two's complement
//  SLOT_BITS     16  bclk periods per channel slot; must be >= SAMPLE_WIDTH
//  BCLK_DIV      4   system clocks per bclk half-period; must be >= 2
// PORTS
//  clock         in   1   system clock; all logic on posedge
//  reset         in   1   synchronous, active-low reset
//  left_sample   in   16  left channel sample
//  right_sample  in   16  right channel sample
//  sample_valid  in   1   left/right pair presented
//  sample_ready  out  1   pair accepted on a cycle where valid&&ready
//  bclk          out  1   codec bit clock
//  lrclk         out  1   word select; 0 = left slot, 1 = right slot
//  dacdat        out  1   serial data, MSB first
//  frame_start   out  1   1-cycle pulse when a frame begins (left slot, bit 0)
//  underrun_cnt  out  8   frames started with empty buffer; saturates at 255
// BEHAVIOUR
//  Reset (reset==0 at posedge): bclk=0, lrclk=0, dacdat=0, sample_ready=0,
//   frame_start=0, underrun_cnt=0, buffer empty, frame reg=0, counters=0.
//   Mid-frame reset aborts the frame. No partial bits follow.
//   sample_ready=1 from the first cycle after reset release.
//  Clocking: div_cnt counts 0..BCLK_DIV-1. At terminal count bclk toggles.
//   The 1->0 toggle is a "fall" event. First fall comes 2*BCLK_DIV-1 cycles
//   after reset release.
//  bit_cnt counts 0..2*SLOT_BITS-1 and advances on each fall, wrapping to 0.
//  On a fall: lrclk <= (new bit_cnt >= SLOT_BITS).
//   dacdat <= frame bit for new bit_cnt.
//  I2S one-bclk delay:
//   slot offset k=1..SAMPLE_WIDTH carries sample[SAMPLE_WIDTH-k].
//   Offsets > SAMPLE_WIDTH carry 0.
//   Offset 0 carries the LSB of the previous slot when SLOT_BITS==SAMPLE_WIDTH,
//   otherwise 0.
//  Frame load: on the fall where bit_cnt becomes 0, frame_start pulses.
//   If the buffer is full, the buffer moves to the frame reg and the buffer empties.
//   If the buffer is empty (underrun), the frame reg takes the underrun value
//   (see CONFIGURATION) and underrun_cnt increments, saturating at 255.
//   The previous right LSB is still emitted at offset 0.
//  Handshake: sample_ready = !buffer_full || load_this_cycle.
//   A pair accepted on the load cycle refills the buffer the same cycle, so
//   there is no bubble. valid held while ready==0 is stalled; data must stay stable.
//  Throughput: one pair per 2*SLOT_BITS*2*BCLK_DIV clocks (256 at defaults).
//  Latency: a pair accepted into an empty buffer with the serializer idle starts
//   at the next frame_start. MSB appears one bclk period after that.
// CONFIGURATION
//  UNDERRUN_REPEAT_EN defined: on underrun the frame reg keeps its previous
//   contents, so the last pair is retransmitted.
//  Not defined: on underrun the frame reg is loaded with 0 (silence).
//  underrun_cnt behaves the same in both builds.
// TESTING (SLOT_BITS=16, BCLK_DIV=4; bclk period 8 clocks)
//  Reset: hold reset=0 for 5 cycles.
//   -> all outputs 0; sample_ready=1 on the cycle after release.
//  Single pair: L=16'hA5F0, R=16'h0F0F, pulse valid.
//   -> next frame left offsets 1..16 = 1010_0101_1111_0000.
//   -> right offsets 1..16 = 0000_1111_0000_1111, with lrclk=1.
//   -> next frame offset 0 = 1 (R LSB).
//  Back-to-back: hold valid with an incrementing pair each accept.
//   -> exactly one accept per 256 clocks; no underrun_cnt change.
//   -> accept cycle coincides with frame_start.
//  Underrun: stop valid after L=16'h8001.
//   -> next frame is 16'h8001 with REPEAT_EN, else zeros.
//   -> underrun_cnt increments once per empty frame; saturates at 255 after 300 frames.
//  Reset mid-frame: assert reset at left offset 7.
//   -> outputs 0 the next cycle; buffer cleared.
//   -> first post-reset frame_start emits zeros or fresh data only.
//  Backpressure: assert valid while the buffer is full, away from a load.
//   -> sample_ready=0; the pair is accepted only on the frame_start cycle.

Source files
------------

// File: rtl/i2s_dac_serializer.sv
// I2S transmit serializer: one-pair holding buffer feeding a frame register shifted out on dacdat.
// Build option UNDERRUN_REPEAT_EN: on underrun retransmit the last pair instead of silence.

module i2s_dac_serializer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_BITS    = 16,
  parameter int unsigned BCLK_DIV     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    dacdat,
  output logic                    frame_start,
  output logic [7:0]              underrun_cnt
);

  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned IDX_W      = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] RIGHT_FIRST  = CNT_W'(SLOT_BITS);
  localparam bit               LSB_CARRY    = (SLOT_BITS == SAMPLE_WIDTH);

  logic [DIV_W-1:0]        div_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    buf_full;
  logic [SAMPLE_WIDTH-1:0] buf_left;
  logic [SAMPLE_WIDTH-1:0] buf_right;
  logic [SAMPLE_WIDTH-1:0] frame_left;
  logic [SAMPLE_WIDTH-1:0] frame_right;

  logic                    div_wrap_c;
  logic                    fall_c;
  logic [CNT_W-1:0]        bit_nxt_c;
  logic                    right_slot_c;
  logic [CNT_W-1:0]        slot_off_c;
  logic [SAMPLE_WIDTH-1:0] slot_sample_c;
  logic                    prev_lsb_c;
  logic                    bit_c;
  logic                    accept_c;
  logic                    buf_full_nxt_c;
  logic                    start_nxt_c;

  // Bit timing, next serial bit and handshake decode.
  always_comb begin
    div_wrap_c     = (div_cnt == DIV_LAST);
    fall_c         = div_wrap_c && bclk;
    bit_nxt_c      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    right_slot_c   = (bit_nxt_c >= RIGHT_FIRST);
    slot_off_c     = right_slot_c ? (bit_nxt_c - RIGHT_FIRST) : bit_nxt_c;
    slot_sample_c  = right_slot_c ? frame_right : frame_left;
    // Offset 0 of each slot carries the LSB that the one-bclk delay pushed out of the previous slot.
    prev_lsb_c     = right_slot_c ? frame_left[0] : frame_right[0];
    bit_c          = 1'b0;
    if (slot_off_c == '0) begin
      bit_c = LSB_CARRY ? prev_lsb_c : 1'b0;
    end else if (32'(slot_off_c) <= SAMPLE_WIDTH) begin
      bit_c = slot_sample_c[IDX_W'(SAMPLE_WIDTH - 32'(slot_off_c))];
    end
    accept_c       = sample_valid && sample_ready;
    // frame_start high marks the load cycle: the buffer drains into the frame reg at its end.
    buf_full_nxt_c = accept_c || (buf_full && !frame_start);
    start_nxt_c    = fall_c && (bit_nxt_c == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      dacdat       <= 1'b0;
      frame_start  <= 1'b0;
      sample_ready <= 1'b0;
      underrun_cnt <= '0;
      buf_full     <= 1'b0;
      buf_left     <= '0;
      buf_right    <= '0;
      frame_left   <= '0;
      frame_right  <= '0;
    end else begin
      div_cnt      <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap_c) begin
        bclk <= ~bclk;
      end
      frame_start  <= start_nxt_c;
      sample_ready <= !buf_full_nxt_c || start_nxt_c;
      buf_full     <= buf_full_nxt_c;

      if (fall_c) begin
        bit_cnt <= bit_nxt_c;
        lrclk   <= right_slot_c;
        dacdat  <= bit_c;
      end

      if (accept_c) begin
        buf_left  <= left_sample;
        buf_right <= right_sample;
      end

      // Frame load; an accept in the same cycle refills the buffer without a bubble.
      if (frame_start) begin
        if (buf_full) begin
          frame_left  <= buf_left;
          frame_right <= buf_right;
        end else begin
`ifdef UNDERRUN_REPEAT_EN
          frame_left  <= frame_left;
          frame_right <= frame_right;
`else
          frame_left  <= '0;
          frame_right <= '0;
`endif
          if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: a cycle-count/bitstream reference model checks every cycle,
// plus table-driven frame words and hand sequences for handshake, underrun and reset corners.

module tb_i2s_dac_serializer;

  localparam int unsigned SW        = 16;
  localparam int unsigned SB        = 16;
  localparam int unsigned BD        = 4;
  localparam int unsigned FRAME_CYC = 2 * SB * 2 * BD;

  logic          clock = 1'b0;
  logic          reset;
  logic [SW-1:0] left_sample;
  logic [SW-1:0] right_sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          bclk;
  logic          lrclk;
  logic          dacdat;
  logic          frame_start;
  logic [7:0]    underrun_cnt;

  i2s_dac_serializer #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SB), .BCLK_DIV(BD)) dut (
    .clock        (clock),
    .reset        (reset),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .dacdat       (dacdat),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[5];

  int          checks;
  int          errors;
  int unsigned fs_seen;
  logic [31:0] cap_word;

  // Reference model: cycles since release, a one-deep buffer and the expected serial bitstream.
  int unsigned cyc;
  bit          m_full;
  logic [15:0] m_bl;
  logic [15:0] m_br;
  logic [31:0] m_frame;
  int unsigned m_ucnt;
  bit          m_dat;
  bit          m_lr;
  bit          bitq[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    cyc     = 0;
    m_full  = 1'b0;
    m_frame = '0;
    m_ucnt  = 0;
    m_dat   = 1'b0;
    m_lr    = 1'b0;
    bitq.delete();
    // Zero frame already in flight plus its offset-0 successor bit.
    for (int i = 0; i < int'(2 * SB); i++) bitq.push_back(1'b0);
  endfunction

  // Check the current window, drive inputs for the next posedge, advance the model.
  task automatic step(input bit rst_n, input bit v, input logic [15:0] l, input logic [15:0] r);
    bit          fall;
    bit          fs;
    bit          rdy;
    int unsigned n;
    fall = (cyc != 0) && (cyc % (2 * BD) == 0);
    n    = cyc / (2 * BD);
    fs   = fall && (n % (2 * SB) == 0);
    rdy  = (cyc != 0) && (!m_full || fs);
    if (fall) begin
      m_dat = (bitq.size() != 0) ? bitq.pop_front() : 1'b0;
      m_lr  = (n % (2 * SB)) >= SB;
      cap_word = {cap_word[30:0], dacdat};
    end
    check("bclk", 32'(bclk), 32'((cyc / BD) % 2));
    check("frame_start", 32'(frame_start), 32'(fs));
    check("sample_ready", 32'(sample_ready), 32'(rdy));
    check("underrun_cnt", 32'(underrun_cnt), m_ucnt);
    check("dacdat", 32'(dacdat), 32'(m_dat));
    check("lrclk", 32'(lrclk), 32'(m_lr));
    if (fs) fs_seen++;

    reset        = rst_n;
    sample_valid = v;
    left_sample  = l;
    right_sample = r;

    if (!rst_n) begin
      model_reset();
    end else begin
      if (fs) begin
        if (m_full) begin
          m_frame = {m_bl, m_br};
          m_full  = 1'b0;
        end else begin
`ifndef UNDERRUN_REPEAT_EN
          m_frame = '0;
`endif
          if (m_ucnt < 255) m_ucnt++;
        end
        for (int i = 31; i >= 0; i--) bitq.push_back(m_frame[i]);
      end
      if (v && rdy) begin
        m_bl   = l;
        m_br   = r;
        m_full = 1'b1;
      end
      cyc++;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) step(1'b1, 1'b0, '0, '0);
  endtask

  task automatic wait_fs(input int unsigned cnt, input string name);
    int unsigned seen0;
    int unsigned k;
    seen0 = fs_seen;
    k     = 0;
    while ((fs_seen - seen0) < cnt && k < cnt * FRAME_CYC + 16) begin
      idle(1);
      k++;
    end
    check(name, fs_seen - seen0, cnt);
  endtask

  task automatic wait_ready(input string name);
    int unsigned k;
    k = 0;
    while (!sample_ready && k < 2 * FRAME_CYC) begin
      idle(1);
      k++;
    end
    check(name, 32'(sample_ready), 32'd1);
  endtask

  // Offer one pair into an idle buffer, return the word seen on dacdat for its frame.
  task automatic run_pair(input logic [15:0] l, input logic [15:0] r, output logic [31:0] got);
    wait_ready("pair_ready");
    step(1'b1, 1'b1, l, r);
    wait_fs(2, "pair_frame_wait");
    got = cap_word;
  endtask

  initial begin
    logic [31:0] got;
    int unsigned u0;
    int          acc;
    int          off_fs;
    logic [15:0] d;
    bit          was_rdy;
    bit          was_fs;
    bit          pv;
    logic [15:0] pl;
    logic [15:0] pr;

    checks   = 0;
    errors   = 0;
    fs_seen  = 0;
    cap_word = '0;
    reset        = 1'b0;
    sample_valid = 1'b0;
    left_sample  = '0;
    right_sample = '0;

    vecs[0] = '{l: 16'hA5F0, r: 16'h0F0F, word: 32'b1010_0101_1111_0000_0000_1111_0000_1111};
    vecs[1] = '{l: 16'hFFFF, r: 16'hFFFF, word: 32'hFFFF_FFFF};
    vecs[2] = '{l: 16'h0000, r: 16'h0000, word: 32'h0000_0000};
    vecs[3] = '{l: 16'h7FFF, r: 16'h8000, word: 32'h7FFF_8000};
    vecs[4] = '{l: 16'h1234, r: 16'hFEDC, word: 32'h1234_FEDC};

    // Reset held five cycles.
    @(posedge clock);
    @(negedge clock);
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0);
    check("reset_outputs", {19'd0, bclk, lrclk, dacdat, frame_start, sample_ready, underrun_cnt}, 32'd0);
    step(1'b1, 1'b0, '0, '0);
    check("ready_after_release", 32'(sample_ready), 32'd1);

    // Table-driven single pairs.
    for (int i = 0; i < 5; i++) begin
      run_pair(vecs[i].l, vecs[i].r, got);
      check("vec_word", got, vecs[i].word);
    end

    // Underrun after a lone pair: repeat or silence.
    run_pair(16'h8001, 16'h0001, got);
    check("u_pair_word", got, 32'h8001_0001);
    u0 = m_ucnt;
    wait_fs(1, "u_frame_wait");
`ifdef UNDERRUN_REPEAT_EN
    check("underrun_frame", cap_word, 32'h8001_0001);
`else
    check("underrun_frame", cap_word, 32'h0000_0000);
`endif
    idle(2);
    check("underrun_inc", 32'(underrun_cnt), u0 + 1);

    // Backpressure: fill the buffer mid-frame, then offer another pair.
    wait_fs(1, "bp_sync");
    idle(20);
    check("bp_ready_empty", 32'(sample_ready), 32'd1);
    step(1'b1, 1'b1, 16'hC0DE, 16'hBEEF);
    check("bp_ready_full", 32'(sample_ready), 32'd0);
    acc = 0;
    while (!sample_ready && acc < int'(2 * FRAME_CYC)) begin
      step(1'b1, 1'b1, 16'h5A5A, 16'hA5A5);
      acc++;
    end
    check("bp_accept_on_fs", 32'(frame_start), 32'd1);
    step(1'b1, 1'b1, 16'h5A5A, 16'hA5A5);
    wait_fs(1, "bp_wait1");
    check("bp_first_word", cap_word, 32'hC0DE_BEEF);
    wait_fs(1, "bp_wait2");
    check("bp_second_word", cap_word, 32'h5A5A_A5A5);

    // Back-to-back: valid held, fresh pair after every accept.
    d = 16'h1000;
    for (int unsigned i = 0; i < FRAME_CYC + 44; i++) begin
      was_rdy = sample_ready;
      step(1'b1, 1'b1, d, ~d);
      if (was_rdy) d++;
    end
    u0     = m_ucnt;
    acc    = 0;
    off_fs = 0;
    for (int unsigned i = 0; i < 4 * FRAME_CYC; i++) begin
      was_rdy = sample_ready;
      was_fs  = frame_start;
      step(1'b1, 1'b1, d, ~d);
      if (was_rdy) begin
        acc++;
        if (!was_fs) off_fs++;
        d++;
      end
    end
    check("b2b_accepts", 32'(acc), 32'd4);
    check("b2b_accept_off_fs", 32'(off_fs), 32'd0);
    check("b2b_no_underrun", 32'(underrun_cnt), u0);

    // Reset at left offset 7 of a live frame.
    idle(2 * FRAME_CYC);
    wait_ready("mr_ready");
    step(1'b1, 1'b1, 16'hC3C3, 16'h3C3C);
    wait_fs(1, "mr_load");
    idle(7 * 2 * BD - 1);
    check("mr_at_offset7", 32'(dacdat), 32'd1);
    step(1'b0, 1'b0, '0, '0);
    check("mr_outputs_zero", {19'd0, bclk, lrclk, dacdat, frame_start, sample_ready, underrun_cnt}, 32'd0);
    step(1'b1, 1'b0, '0, '0);
    wait_fs(2, "mr_post_wait");
    check("mr_post_frame", cap_word, 32'd0);

    // Randomized traffic with stalls; valid and data held until accepted.
    pv = 1'b0;
    pl = '0;
    pr = '0;
    for (int unsigned i = 0; i < 10 * FRAME_CYC; i++) begin
      if (!pv && $urandom_range(0, 99) < 2) begin
        pv = 1'b1;
        pl = 16'($urandom);
        pr = 16'($urandom);
      end
      was_rdy = sample_ready;
      step(1'b1, pv, pl, pr);
      if (pv && was_rdy) pv = 1'b0;
    end

    // Long idle: underrun counter saturates.
    idle(260 * FRAME_CYC);
    check("underrun_sat", 32'(underrun_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
